// File: rtl/fp_mant_mul_pipe_param.sv
// Pipelined, back-pressurable significand multiplier.
// Produces either one MWxMW product or two independent HWxHW lane products.
// Stage 1 forms split partial products. Middle stages carry them forward.
// The last stage performs the single carry-propagate add into mant_prod.
// A global advance signal freezes every stage while the output is blocked.
module fp_mant_mul_pipe_param #(
  parameter int MW     = 53,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_dual,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [MW-1:0]       mant_a,
  input  logic [MW-1:0]       mant_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_dual,
  output logic [TAG_W-1:0]    out_tag,
  output logic [2*MW-1:0]     mant_prod,
  output logic                busy
);

  localparam int HW = MW / 2;   // low split / dual-lane width
  localparam int LW = MW - HW;  // high split width (HW+1 for odd MW)
  localparam int PW = 2 * MW;

  // Partial products for a = ah*2^HW + al, b = bh*2^HW + bl.
  // Dual mode is the same sum with cross terms forced to zero and ah/bh
  // masked to HW bits, so one final adder serves both modes.
  typedef struct packed {
    logic             dual;
    logic [TAG_W-1:0] tag;
    logic [2*LW-1:0]  hh;
    logic [MW-1:0]    c1;
    logic [MW-1:0]    c2;
    logic [2*HW-1:0]  ll;
  } pp_t;

  logic              en;
  logic              accept;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;
  logic [HW-1:0]     al, bl;
  logic [LW-1:0]     ah, bh;
  pp_t               pp_new;
  pp_t               pp [1:STAGES-1];
  pp_t               pp_last;
  logic [PW-1:0]     sum;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign accept    = in_valid && en;
  assign out_valid = vld_q[STAGES];
  assign busy      = |vld_q;

  // Valid chain with the accept strobe as the entry bit.
  always_comb vld_pipe = {vld_q, accept};

  // Operand split and stage-1 partial products.
  always_comb begin
    al = mant_a[HW-1:0];
    bl = mant_b[HW-1:0];
    ah = in_dual ? LW'(mant_a[2*HW-1:HW]) : mant_a[MW-1:HW];
    bh = in_dual ? LW'(mant_b[2*HW-1:HW]) : mant_b[MW-1:HW];
    pp_new      = '0;
    pp_new.dual = in_dual;
    pp_new.tag  = in_tag;
    pp_new.ll   = (2*HW)'(al) * (2*HW)'(bl);
    pp_new.hh   = (2*LW)'(ah) * (2*LW)'(bh);
    pp_new.c1   = in_dual ? '0 : MW'(ah) * MW'(bl);
    pp_new.c2   = in_dual ? '0 : MW'(al) * MW'(bh);
  end

  // Final carry-propagate add of the aligned partial products.
  always_comb begin
    pp_last = pp[STAGES-1];
    sum = (PW'(pp_last.hh) << (2*HW))
        + ((PW'(pp_last.c1) + PW'(pp_last.c2)) << HW)
        + PW'(pp_last.ll);
  end

  // Pipeline advance: everything shifts on en, data loads only behind a valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      mant_prod <= '0;
      out_tag   <= '0;
      out_dual  <= 1'b0;
    end else if (en) begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (accept) pp[1] <= pp_new;
      for (int s = 2; s <= STAGES-1; s++)
        if (vld_pipe[s-1]) pp[s] <= pp[s-1];
      if (vld_pipe[STAGES-1]) begin
        mant_prod <= sum;
        out_tag   <= pp_last.tag;
        out_dual  <= pp_last.dual;
      end
    end
  end

endmodule

// File: tb/tb_fp_mant_mul_pipe_param.sv
// Scoreboard bench for fp_mant_mul_pipe_param (MW=53, STAGES=3, TAG_W=4).
module tb_fp_mant_mul_pipe_param;
  localparam int MW = 53;
  localparam int ST = 3;
  localparam int TW = 4;
  localparam int PW = 2 * MW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_dual, out_valid, out_ready, out_dual, busy;
  logic [TW-1:0] in_tag, out_tag;
  logic [MW-1:0] mant_a, mant_b;
  logic [PW-1:0] mant_prod;

  fp_mant_mul_pipe_param #(.MW(MW), .STAGES(ST), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dual(in_dual), .in_tag(in_tag), .mant_a(mant_a), .mant_b(mant_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_dual(out_dual),
    .out_tag(out_tag), .mant_prod(mant_prod), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PW-1:0] p; logic [TW-1:0] t; logic d; } exp_t;
  exp_t exp_q[$];
  int   pop_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rec = 0;

  task automatic chk(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] model(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic d);
    logic [51:0] lo, hi;
    if (!d) return {53'd0, a} * {53'd0, b};
    lo = {26'd0, a[25:0]}  * {26'd0, b[25:0]};
    hi = {26'd0, a[51:26]} * {26'd0, b[51:26]};
    return {2'b00, hi, lo};
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: pop and compare on every completed output handshake.
  always begin
    exp_t e;
    @(negedge clk); #3;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output: got tag %0d prod %h, expected none", out_tag, mant_prod);
      end else begin
        e = exp_q.pop_front();
        chk("prod", mant_prod, e.p);
        chk("tag", PW'(out_tag), PW'(e.t));
        chk("dual", PW'(out_dual), PW'(e.d));
        if (rec) pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic issue(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic d,
                       input logic [TW-1:0] t, input logic [PW-1:0] e);
    int g = 0;
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1; mant_a = a; mant_b = b; in_dual = d; in_tag = t;
    #1;
    while (!in_ready && g < 50) begin @(negedge clk); #1; g++; end
    if (!in_ready) begin
      chk("issue_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      x.p = e; x.t = t; x.d = d;
      exp_q.push_back(x);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // Called right after issue() returns (just past the accept edge), pipe empty.
  task automatic latency_check();
    chk("lat_edge0", PW'(out_valid), 0);
    for (int i = 1; i <= ST - 2; i++) begin
      @(posedge clk); #1;
      chk("lat_early", PW'(out_valid), 0);
    end
    @(posedge clk); #1;
    chk("lat_valid", PW'(out_valid), 1);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin @(negedge clk); g++; end
    chk("drain", PW'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [MW-1:0] a, b;
    logic d;
    rst = 1'b1; in_valid = 1'b0; in_dual = 1'b0; in_tag = '0;
    mant_a = '0; mant_b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; #3;
    chk("rst_out_valid", PW'(out_valid), 0);
    chk("rst_busy", PW'(busy), 0);
    chk("rst_prod", mant_prod, 0);
    chk("rst_tag", PW'(out_tag), 0);
    chk("rst_dual", PW'(out_dual), 0);
    chk("rst_in_ready", PW'(in_ready), 1);

    // T1: 1.0 * 1.0
    issue(53'd1 << 52, 53'd1 << 52, 1'b0, 4'h5, 106'd1 << 104);
    latency_check();
    drain();

    // T2: all-ones and zero operand
    issue({53{1'b1}}, {53{1'b1}}, 1'b0, 4'h6, {52'hFFFFFFFFFFFFF, 53'd0, 1'b1});
    issue(53'd0, {53{1'b1}}, 1'b0, 4'h7, 106'd0);
    drain();

    // T3: dual lanes; top operand bit ignored in the second vector
    issue({27'h0, 26'h3FFFFFF}, {27'h0, 26'h3FFFFFF}, 1'b1, 4'h8,
          {54'd0, 25'h1FFFFFF, 26'd0, 1'b1});
    issue({1'b1, 26'h2000000, 26'h0}, {1'b1, 26'h2, 26'h0}, 1'b1, 4'h9,
          {2'b00, 52'h4000000, 52'd0});
    // Dual then single back-to-back
    issue(53'd3, 53'd5, 1'b0, 4'hA, 106'd15);
    drain();

    // T4: 20 back-to-back random ops
    pop_cyc.delete();
    rec = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      a = ra[MW-1:0]; b = rb[MW-1:0]; d = ra[63];
      issue(a, b, d, TW'(i), model(a, b, d));
    end
    drain();
    rec = 1'b0;
    chk("stream_count", PW'(pop_cyc.size()), 20);
    if (pop_cyc.size() == 20)
      chk("stream_span", PW'(pop_cyc[19] - pop_cyc[0]), 19);

    // T5: full pipe held for 5 cycles
    @(negedge clk); out_ready = 1'b0;
    issue(53'd3, 53'd5, 1'b0, 4'h1, 106'd15);
    issue(53'd7, 53'd9, 1'b0, 4'h2, 106'd63);
    issue(53'd11, 53'd13, 1'b0, 4'h3, 106'd143);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      chk("stall_in_ready", PW'(in_ready), 0);
      chk("stall_valid", PW'(out_valid), 1);
      chk("stall_prod", mant_prod, 106'd15);
      chk("stall_tag", PW'(out_tag), 1);
      chk("stall_busy", PW'(busy), 1);
    end
    @(negedge clk); out_ready = 1'b1;
    drain();

    // T6: reset with 3 ops in flight
    @(negedge clk); out_ready = 1'b0;
    issue(53'd2, 53'd2, 1'b0, 4'hB, 106'd4);
    issue(53'd4, 53'd4, 1'b0, 4'hC, 106'd16);
    issue(53'd6, 53'd6, 1'b0, 4'hD, 106'd36);
    @(negedge clk); rst = 1'b1; exp_q.delete();
    @(negedge clk); rst = 1'b0; #3;
    chk("midrst_out_valid", PW'(out_valid), 0);
    chk("midrst_busy", PW'(busy), 0);
    @(negedge clk); out_ready = 1'b1;
    repeat (6) @(negedge clk);
    issue(53'd1 << 52, 53'd3, 1'b0, 4'hE, 106'd3 << 52);
    latency_check();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
